// File: rtl/merge_2to1.sv
// merge_2to1: one node of a streaming merge tree.
// Pops the smaller head of two sorted runs (A wins ties) into a one-entry
// output register that feeds a downstream FIFO. The value 0 terminates a run.
// Exactly one terminator leaves the node for each pair of input runs.
module merge_2to1 #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_a_item,
  input  logic                  i_a_empty,
  output logic                  o_a_read,
  input  logic [DATA_WIDTH-1:0] i_b_item,
  input  logic                  i_b_empty,
  output logic                  o_b_read,
  output logic [DATA_WIDTH-1:0] o_out_item,
  output logic                  o_out_write,
  input  logic                  i_out_full,
  output logic [CNT_WIDTH-1:0]  o_run_count,
  output logic [CNT_WIDTH-1:0]  o_item_count,
  output logic                  o_order_err
);

  typedef enum logic [1:0] {
    ST_MERGE   = 2'd0,
    ST_DRAIN_A = 2'd1,
    ST_DRAIN_B = 2'd2
  } state_e;

  localparam logic [DATA_WIDTH-1:0] ITEM_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Registered state
  state_e                  state_q,     state_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_item_q,  out_item_d;
  logic [DATA_WIDTH-1:0]   last_a_q,    last_a_d;
  logic [DATA_WIDTH-1:0]   last_b_q,    last_b_d;
  logic [CNT_WIDTH-1:0]    run_cnt_q,   run_cnt_d;
  logic [CNT_WIDTH-1:0]    item_cnt_q,  item_cnt_d;
  logic                    order_err_q, order_err_d;

  // Per-cycle decode and control
  logic                    a_zero_s;
  logic                    b_zero_s;
  logic                    a_first_s;
  logic                    out_write_s;
  logic                    load_ok_s;
  logic                    pop_a_s;
  logic                    pop_b_s;
  logic                    a_term_s;
  logic                    b_term_s;
  logic                    load_s;
  logic [DATA_WIDTH-1:0]   load_val_s;
  logic                    a_bad_s;
  logic                    b_bad_s;

  // Classify the two heads and work out whether the output slot can take a new item.
  always_comb begin
    a_zero_s    = (i_a_item == ITEM_ZERO);
    b_zero_s    = (i_b_item == ITEM_ZERO);
    a_first_s   = (i_a_item <= i_b_item);
    out_write_s = out_valid_q & ~i_out_full & ~i_rst;
    load_ok_s   = ~out_valid_q | out_write_s;
  end

  // Merge/drain control: decide which heads pop, what gets loaded and the next state.
  always_comb begin
    state_d    = state_q;
    pop_a_s    = 1'b0;
    pop_b_s    = 1'b0;
    a_term_s   = 1'b0;
    b_term_s   = 1'b0;
    load_s     = 1'b0;
    load_val_s = ITEM_ZERO;
    case (state_q)
      ST_MERGE: begin
        if (load_ok_s && !i_a_empty && !i_b_empty) begin
          if (a_zero_s && b_zero_s) begin
            // Both runs ended together: one terminator for the pair.
            pop_a_s    = 1'b1;
            pop_b_s    = 1'b1;
            a_term_s   = 1'b1;
            b_term_s   = 1'b1;
            load_s     = 1'b1;
            load_val_s = ITEM_ZERO;
          end else if (a_zero_s) begin
            // A is finished; its terminator stays parked at the head while B drains.
            pop_b_s    = 1'b1;
            load_s     = 1'b1;
            load_val_s = i_b_item;
            state_d    = ST_DRAIN_B;
          end else if (b_zero_s) begin
            pop_a_s    = 1'b1;
            load_s     = 1'b1;
            load_val_s = i_a_item;
            state_d    = ST_DRAIN_A;
          end else if (a_first_s) begin
            pop_a_s    = 1'b1;
            load_s     = 1'b1;
            load_val_s = i_a_item;
          end else begin
            pop_b_s    = 1'b1;
            load_s     = 1'b1;
            load_val_s = i_b_item;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN_B: begin
        // The A head is the parked terminator, so A's empty flag is not consulted.
        if (load_ok_s && !i_b_empty) begin
          if (!b_zero_s) begin
            pop_b_s    = 1'b1;
            load_s     = 1'b1;
            load_val_s = i_b_item;
          end else begin
            pop_a_s    = 1'b1;
            pop_b_s    = 1'b1;
            a_term_s   = 1'b1;
            b_term_s   = 1'b1;
            load_s     = 1'b1;
            load_val_s = ITEM_ZERO;
            state_d    = ST_MERGE;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN_A: begin
        // The B head is the parked terminator, so B's empty flag is not consulted.
        if (load_ok_s && !i_a_empty) begin
          if (!a_zero_s) begin
            pop_a_s    = 1'b1;
            load_s     = 1'b1;
            load_val_s = i_a_item;
          end else begin
            pop_a_s    = 1'b1;
            pop_b_s    = 1'b1;
            a_term_s   = 1'b1;
            b_term_s   = 1'b1;
            load_s     = 1'b1;
            load_val_s = ITEM_ZERO;
            state_d    = ST_MERGE;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_MERGE;
      end
    endcase
  end

  // Output slot, statistics counters and per-input ordering monitor.
  always_comb begin
    out_valid_d = out_valid_q;
    out_item_d  = out_item_q;
    run_cnt_d   = run_cnt_q;
    item_cnt_d  = item_cnt_q;
    last_a_d    = last_a_q;
    last_b_d    = last_b_q;
    a_bad_s     = 1'b0;
    b_bad_s     = 1'b0;

    if (load_s) begin
      out_valid_d = 1'b1;
      out_item_d  = load_val_s;
    end else if (out_write_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (load_s && (load_val_s == ITEM_ZERO)) begin
      run_cnt_d = run_cnt_q + CNT_ONE;
    end else if (load_s) begin
      item_cnt_d = item_cnt_q + CNT_ONE;
    end else begin
      run_cnt_d  = run_cnt_q;
      item_cnt_d = item_cnt_q;
    end

    if (pop_a_s && a_term_s) begin
      last_a_d = ITEM_ZERO;
    end else if (pop_a_s) begin
      a_bad_s  = (i_a_item < last_a_q);
      last_a_d = i_a_item;
    end else begin
      last_a_d = last_a_q;
    end

    if (pop_b_s && b_term_s) begin
      last_b_d = ITEM_ZERO;
    end else if (pop_b_s) begin
      b_bad_s  = (i_b_item < last_b_q);
      last_b_d = i_b_item;
    end else begin
      last_b_d = last_b_q;
    end

    order_err_d = order_err_q | a_bad_s | b_bad_s;
  end

  // State registers; reset drops any pending output item.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_MERGE;
      out_valid_q <= 1'b0;
      out_item_q  <= ITEM_ZERO;
      last_a_q    <= ITEM_ZERO;
      last_b_q    <= ITEM_ZERO;
      run_cnt_q   <= CNT_ZERO;
      item_cnt_q  <= CNT_ZERO;
      order_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_item_q  <= out_item_d;
      last_a_q    <= last_a_d;
      last_b_q    <= last_b_d;
      run_cnt_q   <= run_cnt_d;
      item_cnt_q  <= item_cnt_d;
      order_err_q <= order_err_d;
    end
  end

  // FIFO strobes are combinational and held low while reset is asserted.
  assign o_a_read     = pop_a_s & ~i_rst;
  assign o_b_read     = pop_b_s & ~i_rst;
  assign o_out_write  = out_write_s;
  assign o_out_item   = out_item_q;
  assign o_run_count  = run_cnt_q;
  assign o_item_count = item_cnt_q;
  assign o_order_err  = order_err_q;

endmodule
